data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (after the data memory controller's width/sign handling) and the debug unit's memory-dump engine.
- Contains the dump sequencer. On command it walks word addresses 0..N-1, reads each word and hands it to the UART-side debug unit over a valid/ready handshake.
- The pipeline always has priority. Dump reads use only cycles in which the pipeline makes no memory request.

Parameters:
- NB_DATA, 32, data word width.
- NB_ADDR, 10, word-address width of the data memory.
- NB_MASK, 4, byte write-enable width (NB_DATA/8).

Ports:
- i_clock, input, 1, system clock, rising edge.
- i_reset, input, 1, asynchronous, active-low reset.
- i_pipe_mem_read, input, 1, pipeline read request this cycle.
- i_pipe_mem_write, input, 1, pipeline write request this cycle.
- i_pipe_addr, input, NB_ADDR, pipeline word address.
- i_pipe_wdata, input, NB_DATA, pipeline write data (already aligned by the controller).
- i_pipe_wmask, input, NB_MASK, pipeline byte write enables.
- o_pipe_rdata, output, NB_DATA, memory read data to the pipeline, equal to i_mem_rdata.
- i_dump_start, input, 1, one-cycle pulse that starts a dump.
- i_dump_count, input, NB_ADDR+1, number of words to dump; sampled at start.
- o_dump_data, output, NB_DATA, dumped word.
- o_dump_valid, output, 1, o_dump_data is valid.
- i_dump_ready, input, 1, consumer accepts o_dump_data.
- o_dump_busy, output, 1, dump in progress.
- o_dump_done, output, 1, one-cycle pulse when the dump completes.
- o_mem_en, output, 1, memory enable.
- o_mem_we, output, NB_MASK, memory byte write enables.
- o_mem_addr, output, NB_ADDR, memory word address.
- o_mem_wdata, output, NB_DATA, memory write data.
- i_mem_rdata, input, NB_DATA, memory read data; valid 1 cycle after the address (synchronous read).

Behaviour:
- Reset (i_reset=0, asynchronous): FSM goes to IDLE. Address counter and word count clear to 0. o_dump_data=0; o_dump_valid, o_dump_busy and o_dump_done are 0. The memory port outputs are combinational and follow the rules below.
- Memory mux (combinational):
  - pipe_req = i_pipe_mem_read | i_pipe_mem_write.
  - If pipe_req: o_mem_en=1, o_mem_addr=i_pipe_addr, o_mem_wdata=i_pipe_wdata, o_mem_we = i_pipe_mem_write ? i_pipe_wmask : 0.
  - Else, if the FSM is in RD: o_mem_en=1, o_mem_addr=dump address, o_mem_we=0, o_mem_wdata=0.
  - Otherwise all memory outputs are 0.
- A write always takes precedence. The dump never issues a write.
- FSM states:
  - IDLE: on i_dump_start, latch i_dump_count and clear the address. Go to DONE if the count is 0, else to RD. i_dump_start is ignored in every other state.
  - RD: if pipe_req, stay in RD (the dump read is deferred and the address is unchanged). Else the dump read is issued this cycle; go to WAIT.
  - WAIT: register i_mem_rdata into o_dump_data. This capture happens even if the pipeline uses the port this cycle, because the data belongs to the previous cycle's dump address. Go to HOLD.
  - HOLD: o_dump_valid=1 and o_dump_data is held stable. When i_dump_ready=1: if address == count-1, go to DONE; else increment the address and go to RD. o_dump_valid drops the cycle after acceptance.
  - DONE: o_dump_done=1 for exactly one cycle, then go to IDLE.
- o_dump_busy=1 in RD, WAIT, HOLD and DONE.
- Minimum throughput: 3 cycles per word (RD→WAIT→HOLD with ready held high).
- Counting: the address is NB_ADDR bits and the count is NB_ADDR+1 bits. A count of 2^NB_ADDR dumps the whole memory with no address wrap.
- Pipeline reads are never delayed. o_pipe_rdata is valid the cycle after the pipeline address, whatever the dump state.
- An asynchronous reset mid-dump aborts it immediately with no done pulse. The memory receives no dump access after reset is asserted.

Test Plan:
- Reset then idle: all outputs 0; pipeline write addr 5, data 0xDEADBEEF, mask 4'b1111 → o_mem_we=4'hF, o_mem_addr=5. Next-cycle pipeline read of addr 5 → o_pipe_rdata=0xDEADBEEF.
- Dump with count=4, memory preloaded with words 0x10..0x13, ready held 1 → four valid beats carrying 0x10, 0x11, 0x12, 0x13, 3 cycles apart. Then o_dump_done pulses once and o_dump_busy falls.
- Backpressure: ready=0 for 5 cycles while in HOLD → o_dump_valid stays 1 and o_dump_data stays stable. The address advances only after ready=1.
- Contention: pipeline reads every cycle for 6 cycles during RD → dump address held and o_mem_addr tracks i_pipe_addr throughout. The dump resumes on the first free cycle with the correct word.
- count=0 → o_dump_done pulses 1 cycle after start with no memory access. A second start while busy is ignored.
- Assert i_reset low in HOLD → o_dump_valid and o_dump_busy go 0 immediately with no done pulse. After release, a new dump restarts at address 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port data memory between the pipeline MEM stage and the
//   debug memory-dump engine. The pipeline always wins the port; the dump
//   sequencer only reads in cycles the pipeline leaves free, and hands each
//   word to the UART-side debug unit over a valid/ready handshake.
//
// Ports
//   i_clock, i_reset          clock (rising edge), asynchronous active-low reset
//   i_pipe_mem_read/_write    pipeline request strobes for this cycle
//   i_pipe_addr/_wdata/_wmask pipeline word address, aligned data, byte enables
//   o_pipe_rdata              memory read data back to the pipeline
//   i_dump_start/_count       start pulse and number of words (sampled at start)
//   o_dump_data/_valid        dumped word and its valid flag
//   i_dump_ready              consumer accepts o_dump_data
//   o_dump_busy/_done         dump in progress / one-cycle completion pulse
//   o_mem_*                   memory port (enable, byte write enables, addr, data)
//   i_mem_rdata               synchronous-read data, one cycle after the address
module data_mem_arbiter #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_MASK = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_pipe_mem_read,
  input  logic               i_pipe_mem_write,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0] i_pipe_wdata,
  input  logic [NB_MASK-1:0] i_pipe_wmask,
  output logic [NB_DATA-1:0] o_pipe_rdata,
  input  logic               i_dump_start,
  input  logic [NB_ADDR:0]   i_dump_count,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_valid,
  input  logic               i_dump_ready,
  output logic               o_dump_busy,
  output logic               o_dump_done,
  output logic               o_mem_en,
  output logic [NB_MASK-1:0] o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [NB_ADDR:0]   CNT_ONE  = {{NB_ADDR{1'b0}}, 1'b1};
  localparam logic [NB_ADDR-1:0] ADDR_ONE = {{(NB_ADDR-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic [NB_ADDR-1:0]   addr_q;
  logic [NB_ADDR:0]     count_q;
  logic [NB_DATA-1:0]   data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 pipe_req_d;
  logic                 last_word_d;

  assign pipe_req_d = i_pipe_mem_read | i_pipe_mem_write;

  // The count is one bit wider than the address so that a full-memory dump
  // (count = 2^NB_ADDR) ends at the top address without wrapping.
  assign last_word_d = ({1'b0, addr_q} == (count_q - CNT_ONE));

  assign o_pipe_rdata = i_mem_rdata;
  assign o_dump_data  = data_q;
  assign o_dump_valid = valid_q;
  assign o_dump_busy  = busy_q;
  assign o_dump_done  = done_q;

  // Memory port mux: the pipeline owns the port whenever it asks for it; the
  // dump only reads, and only from the RD state.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (pipe_req_d) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_pipe_addr;
      o_mem_wdata = i_pipe_wdata;
      o_mem_we    = i_pipe_mem_write ? i_pipe_wmask : '0;
    end else if (state_q == S_RD) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = addr_q;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_dump_start) begin
            count_q <= i_dump_count;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            if (i_dump_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          // A pipeline request steals the port; retry the same address.
          if (!pipe_req_d) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Read data belongs to last cycle's dump address, so capture it
          // even if the pipeline is using the port now.
          data_q  <= i_mem_rdata;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (i_dump_ready) begin
            valid_q <= 1'b0;
            if (last_word_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + ADDR_ONE;
              state_q <= S_RD;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 10;
  localparam int NB_MASK = 4;
  localparam int DEPTH   = 1 << NB_ADDR;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pipe_rd, pipe_wr;
  logic [NB_ADDR-1:0] pipe_addr;
  logic [NB_DATA-1:0] pipe_wdata;
  logic [NB_MASK-1:0] pipe_wmask;
  logic [NB_DATA-1:0] o_pipe_rdata;
  logic               dump_start;
  logic [NB_ADDR:0]   dump_count;
  logic [NB_DATA-1:0] o_dump_data;
  logic               o_dump_valid;
  logic               dump_ready;
  logic               o_dump_busy, o_dump_done;
  logic               o_mem_en;
  logic [NB_MASK-1:0] o_mem_we;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0] o_mem_wdata;
  logic [NB_DATA-1:0] mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_MASK(NB_MASK)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_pipe_mem_read(pipe_rd), .i_pipe_mem_write(pipe_wr),
    .i_pipe_addr(pipe_addr), .i_pipe_wdata(pipe_wdata), .i_pipe_wmask(pipe_wmask),
    .o_pipe_rdata(o_pipe_rdata),
    .i_dump_start(dump_start), .i_dump_count(dump_count),
    .o_dump_data(o_dump_data), .o_dump_valid(o_dump_valid), .i_dump_ready(dump_ready),
    .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Physical single-port RAM with synchronous, read-first behaviour.
  logic [NB_DATA-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (o_mem_en) begin
      mem_rdata <= ram[o_mem_addr];
      for (int b = 0; b < NB_MASK; b++)
        if (o_mem_we[b]) ram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end

  // Reference model: intended memory contents plus expected-response queues.
  logic [NB_DATA-1:0] ref_mem [DEPTH];
  logic [NB_DATA-1:0] exp_dump_data[$];
  logic [NB_ADDR-1:0] exp_dump_addr[$];
  logic [NB_DATA-1:0] exp_pipe[$];
  int                 exp_done;
  int                 n_pass, n_total;
  logic               pipe_pend;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail(input string name);
    n_total++;
    $display("FAIL %s: event missing or unexpected", name);
  endfunction

  // Monitor: samples on the falling edge, pops expectations as the DUT responds.
  always @(negedge clk) begin
    if (!rst_n) begin
      pipe_pend = 1'b0;
    end else begin
      if (pipe_pend) begin
        if (exp_pipe.size() == 0) fail("pipe_rdata_unexpected");
        else chk("pipe_rdata", o_pipe_rdata, exp_pipe.pop_front());
      end
      pipe_pend = pipe_rd;
      if (pipe_rd | pipe_wr) begin
        chk("mux_pipe_en", o_mem_en, 1);
        chk("mux_pipe_addr", o_mem_addr, pipe_addr);
        chk("mux_pipe_we", o_mem_we, pipe_wr ? pipe_wmask : '0);
        chk("mux_pipe_wdata", o_mem_wdata, pipe_wdata);
      end else if (o_mem_en) begin
        chk("dump_rd_we", o_mem_we, 0);
        chk("dump_rd_wdata", o_mem_wdata, 0);
        if (exp_dump_addr.size() == 0) fail("dump_rd_unexpected");
        else chk("dump_rd_addr", o_mem_addr, exp_dump_addr.pop_front());
      end
      if (o_dump_valid && dump_ready) begin
        if (exp_dump_data.size() == 0) fail("dump_beat_unexpected");
        else chk("dump_beat_data", o_dump_data, exp_dump_data.pop_front());
      end
      if (o_dump_done) begin
        if (exp_done == 0) fail("dump_done_unexpected");
        else begin
          exp_done--;
          chk("done_after_all_beats", exp_dump_data.size(), 0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input int a, input logic [NB_DATA-1:0] d, input logic [NB_MASK-1:0] m);
    pipe_wr = 1'b1; pipe_addr = NB_ADDR'(a); pipe_wdata = d; pipe_wmask = m;
    for (int b = 0; b < NB_MASK; b++)
      if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic set_read(input int a);
    pipe_rd = 1'b1; pipe_addr = NB_ADDR'(a);
    exp_pipe.push_back(ref_mem[a]);
  endtask

  task automatic pipe_idle();
    pipe_rd = 1'b0; pipe_wr = 1'b0;
  endtask

  task automatic start_dump(input int cnt);
    dump_start = 1'b1; dump_count = (NB_ADDR+1)'(cnt);
    for (int a = 0; a < cnt; a++) begin
      exp_dump_data.push_back(ref_mem[a]);
      exp_dump_addr.push_back(NB_ADDR'(a));
    end
    exp_done++;
    cyc();
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input int base, output int cycles);
    cycles = base;
    while (!o_dump_done && cycles < limit) begin
      cyc();
      cycles++;
    end
    if (!o_dump_done) fail("wait_done_timeout");
  endtask

  task automatic wait_valid(input int limit);
    int k = 0;
    while (!o_dump_valid && k < limit) begin
      cyc();
      k++;
    end
    if (!o_dump_valid) fail("wait_valid_timeout");
  endtask

  task automatic run_random(input int limit, input bit allow_wr);
    int  c = 0;
    bit  seen = 1'b0;
    int  op;
    while (!seen && c < limit) begin
      dump_ready = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 2);
      if (op == 1) set_read($urandom_range(0, DEPTH-1));
      else if (op == 2 && allow_wr)
        set_write($urandom_range(16, DEPTH-1), $urandom, NB_MASK'($urandom_range(1, 15)));
      cyc();
      pipe_idle();
      c++;
      seen = o_dump_done;
    end
    if (!seen) fail("rand_dump_timeout");
    dump_ready = 1'b1;
    cyc();
  endtask

  int                 cyc_n;
  logic [NB_DATA-1:0] held;

  initial begin
    n_pass = 0; n_total = 0; exp_done = 0; pipe_pend = 1'b0;
    rst_n = 1'b0; pipe_rd = 1'b0; pipe_wr = 1'b0; pipe_addr = '0;
    pipe_wdata = '0; pipe_wmask = '0; dump_start = 1'b0; dump_count = '0;
    dump_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dump_data", o_dump_data, 0);
    chk("rst_dump_valid", o_dump_valid, 0);
    chk("rst_dump_busy", o_dump_busy, 0);
    chk("rst_dump_done", o_dump_done, 0);
    chk("rst_mem_en", o_mem_en, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);
    rst_n = 1'b1;
    cyc();

    // Pipeline write then read-back of address 5.
    set_write(5, 32'hDEADBEEF, 4'hF);
    #1;
    chk("t1_mem_we", o_mem_we, 4'hF);
    chk("t1_mem_addr", o_mem_addr, 5);
    cyc();
    pipe_idle();
    set_read(5);
    cyc();
    pipe_idle();
    chk("t1_pipe_rdata", o_pipe_rdata, 32'hDEADBEEF);

    // Preload the whole memory through the pipeline port.
    for (int a = 0; a < DEPTH; a++) begin
      set_write(a, (a < 4) ? 32'h10 + a : $urandom, 4'hF);
      cyc();
      pipe_idle();
    end

    // Four-word dump with ready held high: 3 cycles per word then done.
    dump_ready = 1'b1;
    start_dump(4);
    wait_done(100, 1, cyc_n);
    chk("t2_latency", cyc_n, 13);
    cyc();
    chk("t2_busy_fall", o_dump_busy, 0);

    // Backpressure in HOLD.
    dump_ready = 1'b0;
    start_dump(2);
    wait_valid(20);
    held = o_dump_data;
    chk("t3_first_word", held, 32'h10);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_valid_held", o_dump_valid, 1);
      chk("t3_data_held", o_dump_data, held);
    end
    dump_ready = 1'b1;
    wait_done(50, 0, cyc_n);
    cyc();

    // Pipeline reads every cycle while the dump sits in RD.
    start_dump(3);
    for (int i = 0; i < 6; i++) begin
      set_read($urandom_range(0, DEPTH-1));
      cyc();
      chk("t4_busy", o_dump_busy, 1);
      chk("t4_no_valid", o_dump_valid, 0);
    end
    pipe_idle();
    wait_done(100, 7, cyc_n);
    chk("t4_latency", cyc_n, 16);
    cyc();

    // Zero-length dump.
    start_dump(0);
    wait_done(10, 1, cyc_n);
    chk("t5_zero_latency", cyc_n, 1);
    cyc();
    chk("t5_busy_fall", o_dump_busy, 0);

    // A second start while busy is ignored.
    start_dump(2);
    cyc();
    dump_start = 1'b1; dump_count = 11'd5;
    cyc();
    dump_start = 1'b0;
    wait_done(50, 3, cyc_n);
    chk("t5_ignore_start_latency", cyc_n, 7);
    cyc();

    // Asynchronous reset while in HOLD aborts the dump.
    dump_ready = 1'b0;
    start_dump(3);
    wait_valid(20);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_cleared", o_dump_valid, 0);
    chk("t6_busy_cleared", o_dump_busy, 0);
    chk("t6_no_done", o_dump_done, 0);
    chk("t6_mem_idle", o_mem_en, 0);
    exp_dump_data.delete();
    exp_dump_addr.delete();
    exp_done = 0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    dump_ready = 1'b1;
    start_dump(2);
    wait_done(50, 1, cyc_n);
    chk("t6_restart_latency", cyc_n, 7);
    cyc();

    // Randomized dumps with mixed pipeline traffic and random backpressure.
    for (int d = 0; d < 6; d++) begin
      start_dump($urandom_range(1, 8));
      run_random(400, 1'b1);
    end

    // Whole-memory dump: count = 2^NB_ADDR.
    start_dump(DEPTH);
    run_random(20000, 1'b0);

    cyc();
    chk("end_dump_queue_empty", exp_dump_data.size(), 0);
    chk("end_addr_queue_empty", exp_dump_addr.size(), 0);
    chk("end_pipe_queue_empty", exp_pipe.size(), 0);
    chk("end_done_tokens", exp_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
